cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Hardware run controller for the OoO RISC-V core: sequences core reset, run and halt, and detects program completion.
//  Completion is an end address, or fetch-PC stall with an empty IFQ. Also detects timeout.
//  Counts cycles and committed instructions and holds the results for readout.
//  Sits beside `top`: drives the core's active-high rst; observes imem_addr, ifq_empty and commit.
// PARAMETERS
//  RST_CYCLES    4        cycles core_rst is held high after start
//  STABLE_CYCLES 6        consecutive PC-stable && ifq_empty cycles that declare halt (>=1)
//  END_ADDR      32'h200  PC >= END_ADDR declares halt
//  MAX_CYCLES    500      RUN cycles before timeout (>=1)
//  CNT_W         32       width of the statistics counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      pulse; begins a run (ignored while busy)
//  abort        in   1      pulse; ends the run immediately
//  pc           in   32     core fetch address (imem_addr)
//  ifq_empty    in   1      instruction fetch queue empty
//  commit_valid in   1      one instruction committed this cycle
//  core_rst     out  1      active-high reset to core
//  busy         out  1      high in RESET or RUN
//  done         out  1      run ended by halt detection (sticky until next start)
//  timeout      out  1      run ended by MAX_CYCLES (sticky until next start)
//  cycle_count  out  CNT_W  RUN cycles of the last/current run
//  instr_count  out  CNT_W  commits counted in the last/current run
//  halt_pc      out  32     PC at the halt/timeout/abort cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, core_rst=1, busy=0, done=0, timeout=0, counters=0, halt_pc=0.
//  - States:
//    - IDLE: core_rst=1. On start, clear done, timeout, counters and stall count; go to RESET.
//    - RESET: core_rst=1 for exactly RST_CYCLES cycles, then RUN. Cycles are counted by rst_cnt.
//    - RUN: core_rst=0. Each cycle, cycle_count+=1 and instr_count+=commit_valid.
//    - DONE: core_rst=1. Stats are frozen. start -> RESET (as from IDLE).
//  - Counters saturate at all-ones and never wrap.
//  - Stall detector:
//    - prev_pc is registered in RUN.
//    - stall_cnt increments when pc==prev_pc && ifq_empty, else clears.
//    - stall_cnt is invalid on the first RUN cycle and stays 0 there.
//  - Exit from RUN, priority order, evaluated on the same edge as the counter update:
//    - 1. abort: go to DONE with done=0 and timeout=0.
//    - 2. pc>=END_ADDR: done=1.
//    - 3. stall_cnt reaches STABLE_CYCLES while instr_count (including this cycle) > 0: done=1.
//    - 4. cycle_count reaches MAX_CYCLES: timeout=1.
//    - Each exit latches halt_pc=pc and goes to DONE.
//  - The exiting cycle is counted. done and timeout are never set together.
//  - abort in RESET goes to DONE with counters at 0. abort in IDLE or DONE is ignored.
//  - start while busy is ignored. start and abort in the same IDLE cycle: start wins.
//  - A stalled PC with instr_count==0 never declares halt; only timeout or abort ends the run.
//  - Asserting rst_n mid-run returns to IDLE at once and clears all stats.
// STRUCTURE
//  - run_ctrl_pkg:
//    - run_state_e {IDLE, RESET, RUN, DONE}
//    - exit_cause_e {EXIT_NONE, EXIT_ADDR, EXIT_STALL, EXIT_TIMEOUT, EXIT_ABORT}
//    - saturating-increment function
//  - Sub-module pc_stall_detector (pc, ifq_empty, en, clr -> stall_cnt, stall_hit) owns prev_pc and stall_cnt.
//  - Top level holds the FSM, counters and output registers; all outputs are registered.
// TESTING
//  - Reset then start:
//    - core_rst high for 4 cycles after start, then low; busy high from the cycle after start.
//  - Linear program:
//    - PC steps 0,4,...,0x1FC then 0x200, with 128 commits.
//    - Expect done=1, halt_pc=0x200, instr_count=128, cycle_count = RUN cycles inclusive.
//  - Stall halt:
//    - PC held at 0x40 with ifq_empty=1 after 10 commits.
//    - Expect done on the 6th stable cycle, halt_pc=0x40, instr_count=10.
//    - With ifq_empty toggling low at stable cycle 3, the count restarts.
//  - No-commit stall:
//    - PC stuck at 0 with ifq_empty=1, MAX_CYCLES=20.
//    - Expect timeout=1, done=0, cycle_count=20.
//  - Abort and restart:
//    - abort at RUN cycle 7 gives DONE with done=timeout=0 and cycle_count=7.
//    - A following start clears stats and re-enters RESET.
//    - start while busy is ignored.
//  - Async reset mid-RUN:
//    - rst_n low between clock edges gives immediate core_rst=1, busy=0, counters=0, state IDLE.
//  - Saturation:
//    - CNT_W=4, MAX_CYCLES=40, commit every cycle.
//    - instr_count holds at 15 and timeout fires at 40 RUN cycles (cycle_count stays 15).

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the core run controller: FSM states, exit causes,
// PC type and a width-generic saturating increment.
package run_ctrl_pkg;

  localparam int unsigned PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } run_state_e;

  typedef enum logic [2:0] {
    EXIT_NONE,
    EXIT_ADDR,
    EXIT_STALL,
    EXIT_TIMEOUT,
    EXIT_ABORT
  } exit_cause_e;

  // Counters of any width up to 64 are zero-extended in, incremented, and sliced back out.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic inc,
                                          input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (inc && (v < lim)) ? v + 64'd1 : v;
  endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Tracks how many consecutive RUN cycles the fetch PC has stayed put with an empty IFQ.
// stall_hit is combinational for the current cycle; stall_cnt is the registered run length so far.
module pc_stall_detector
  import run_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 6,
  parameter int unsigned SCW           = $clog2(STABLE_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  pc_t            pc,
  input  logic           ifq_empty,
  input  logic           en,
  input  logic           clr,
  output logic [SCW-1:0] stall_cnt,
  output logic           stall_hit
);

  localparam logic [SCW-1:0] CNT_MAX = SCW'(STABLE_CYCLES);

  pc_t            prev_pc_q, prev_pc_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           valid_q, valid_d;

  // prev_pc is meaningless until one RUN cycle has registered it.
  assign stall_hit = en && valid_q && (pc == prev_pc_q) && ifq_empty;
  assign stall_cnt = cnt_q;

  always_comb begin
    prev_pc_d = prev_pc_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    if (clr) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (en) begin
      prev_pc_d = pc;
      valid_d   = 1'b1;
      if (stall_hit) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + SCW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      prev_pc_q <= prev_pc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the OoO core: holds core reset, runs, and stops on end address, fetch stall,
// timeout or abort. All outputs registered; start is ignored while busy, abort is honoured in RESET/RUN.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned STABLE_CYCLES = 6,
  parameter logic [31:0] END_ADDR      = 32'h200,
  parameter int unsigned MAX_CYCLES    = 500,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      pc,
  input  logic             ifq_empty,
  input  logic             commit_valid,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [31:0]      halt_pc
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned TCW = $clog2(MAX_CYCLES + 1);
  localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(MAX_CYCLES - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STABLE_CYCLES - 1);

  run_state_e       state_q, state_d;
  exit_cause_e      exit_cause;

  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] instr_run;
  pc_t              halt_pc_q, halt_pc_d;
  logic             core_rst_q, core_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             start_acc;
  logic             in_run;
  logic [SCW-1:0]   stall_cnt;
  logic             stall_hit;
  logic             stall_reached;

  assign in_run    = (state_q == RUN);
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  // Commit count including this cycle, so a halt on the first commit's cycle still qualifies.
  assign instr_run     = CNT_W'(sat_inc(64'(instr_q), commit_valid, CNT_W));
  assign stall_reached = stall_hit && (stall_cnt >= STALL_LAST);

  pc_stall_detector #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SCW           (SCW)
  ) u_stall (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .ifq_empty (ifq_empty),
    .en        (in_run),
    .clr       (start_acc),
    .stall_cnt (stall_cnt),
    .stall_hit (stall_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exit_cause = EXIT_NONE;
    case (state_q)
      IDLE: begin
        if (start) state_d = RESET;
      end
      RESET: begin
        if (abort) begin
          exit_cause = EXIT_ABORT;
          state_d    = DONE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort)                              exit_cause = EXIT_ABORT;
        else if (pc >= END_ADDR)                exit_cause = EXIT_ADDR;
        else if (stall_reached && |instr_run)   exit_cause = EXIT_STALL;
        else if (tmo_q == TMO_LAST)             exit_cause = EXIT_TIMEOUT;
        if (exit_cause != EXIT_NONE) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = RESET;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_rst_d = (state_d != RUN);
    busy_d     = (state_d == RESET) || (state_d == RUN);
  end

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    tmo_d     = tmo_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    halt_pc_d = halt_pc_q;
    done_d    = done_q;
    timeout_d = timeout_q;

    if (start_acc) begin
      rst_cnt_d = '0;
      tmo_d     = '0;
      cycle_d   = '0;
      instr_d   = '0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end

    if (state_q == RESET) rst_cnt_d = rst_cnt_q + RCW'(1);

    // The exiting RUN cycle is counted like any other.
    if (in_run) begin
      tmo_d   = tmo_q + TCW'(1);
      cycle_d = CNT_W'(sat_inc(64'(cycle_q), 1'b1, CNT_W));
      instr_d = instr_run;
    end

    if (exit_cause != EXIT_NONE) begin
      halt_pc_d = pc;
      done_d    = (exit_cause == EXIT_ADDR) || (exit_cause == EXIT_STALL);
      timeout_d = (exit_cause == EXIT_TIMEOUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q  <= '0;
      tmo_q      <= '0;
      cycle_q    <= '0;
      instr_q    <= '0;
      halt_pc_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      tmo_q      <= tmo_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      halt_pc_q  <= halt_pc_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances (default, short timeout, 4-bit counters) share stimulus;
// expectations are queued when a scenario is driven and popped against the DUT outputs afterwards.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] pc;
  logic        ifq_empty;
  logic        commit_valid;

  logic        a_core_rst, a_busy, a_done, a_timeout;
  logic [31:0] a_cycle, a_instr, a_halt_pc;
  logic        b_core_rst, b_busy, b_done, b_timeout;
  logic [31:0] b_cycle, b_instr, b_halt_pc;
  logic        c_core_rst, c_busy, c_done, c_timeout;
  logic [3:0]  c_cycle, c_instr;
  logic [31:0] c_halt_pc;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pc(pc),
    .ifq_empty(ifq_empty), .commit_valid(commit_valid),
    .core_rst(a_core_rst), .busy(a_busy), .done(a_done), .timeout(a_timeout),
    .cycle_count(a_cycle), .instr_count(a_instr), .halt_pc(a_halt_pc)
  );

  cpu_run_ctrl #(.MAX_CYCLES(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pc(pc),
    .ifq_empty(ifq_empty), .commit_valid(commit_valid),
    .core_rst(b_core_rst), .busy(b_busy), .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cycle), .instr_count(b_instr), .halt_pc(b_halt_pc)
  );

  cpu_run_ctrl #(.MAX_CYCLES(40), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pc(pc),
    .ifq_empty(ifq_empty), .commit_valid(commit_valid),
    .core_rst(c_core_rst), .busy(c_busy), .done(c_done), .timeout(c_timeout),
    .cycle_count(c_cycle), .instr_count(c_instr), .halt_pc(c_halt_pc)
  );

  task automatic expect_v(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cyc(input logic [31:0] p, input logic ifq, input logic cv);
    pc           = p;
    ifq_empty    = ifq;
    commit_valid = cv;
    step();
  endtask

  // Park every instance in DONE/IDLE, then start and sit out the 4 RESET cycles.
  task automatic start_run();
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    pc           = 32'h0;
    ifq_empty    = 1'b0;
    commit_valid = 1'b0;

    // Reset state
    #12;
    expect_v("rst_core_rst", 32'd1); chk(32'(a_core_rst));
    expect_v("rst_busy", 32'd0);     chk(32'(a_busy));
    expect_v("rst_done", 32'd0);     chk(32'(a_done));
    expect_v("rst_timeout", 32'd0);  chk(32'(a_timeout));
    expect_v("rst_cycle", 32'd0);    chk(a_cycle);
    expect_v("rst_instr", 32'd0);    chk(a_instr);
    expect_v("rst_halt_pc", 32'd0);  chk(a_halt_pc);
    rst_n = 1'b1;
    step();

    // Start: busy from the next cycle, core_rst held for exactly 4 cycles
    start = 1'b1;
    step();
    start = 1'b0;
    expect_v("start_busy", 32'd1);     chk(32'(a_busy));
    expect_v("start_core_rst", 32'd1); chk(32'(a_core_rst));
    repeat (3) step();
    expect_v("reset_cyc4_core_rst", 32'd1); chk(32'(a_core_rst));
    step();
    expect_v("run_core_rst", 32'd0); chk(32'(a_core_rst));
    expect_v("run_busy", 32'd1);     chk(32'(a_busy));

    // Linear program to END_ADDR
    for (int i = 0; i < 128; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    expect_v("lin_busy_at_1fc", 32'd1); chk(32'(a_busy));
    run_cyc(32'h200, 1'b0, 1'b0);
    expect_v("lin_done", 32'd1);      chk(32'(a_done));
    expect_v("lin_timeout", 32'd0);   chk(32'(a_timeout));
    expect_v("lin_halt_pc", 32'h200); chk(a_halt_pc);
    expect_v("lin_instr", 32'd128);   chk(a_instr);
    expect_v("lin_cycle", 32'd129);   chk(a_cycle);
    expect_v("lin_busy", 32'd0);      chk(32'(a_busy));
    expect_v("lin_core_rst", 32'd1);  chk(32'(a_core_rst));

    // Stall halt: 10 commits, then PC parked at 0x40 with an empty IFQ
    start_run();
    for (int i = 0; i < 10; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    run_cyc(32'h40, 1'b1, 1'b0);
    repeat (5) run_cyc(32'h40, 1'b1, 1'b0);
    expect_v("stall5_busy", 32'd1); chk(32'(a_busy));
    expect_v("stall5_done", 32'd0); chk(32'(a_done));
    run_cyc(32'h40, 1'b1, 1'b0);
    expect_v("stall_done", 32'd1);     chk(32'(a_done));
    expect_v("stall_halt_pc", 32'h40); chk(a_halt_pc);
    expect_v("stall_instr", 32'd10);   chk(a_instr);
    expect_v("stall_cycle", 32'd17);   chk(a_cycle);
    expect_v("stall_busy", 32'd0);     chk(32'(a_busy));

    // Stall count restarts when ifq_empty drops on stable cycle 3
    start_run();
    for (int i = 0; i < 10; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    run_cyc(32'h40, 1'b1, 1'b0);
    repeat (2) run_cyc(32'h40, 1'b1, 1'b0);
    run_cyc(32'h40, 1'b0, 1'b0);
    repeat (5) run_cyc(32'h40, 1'b1, 1'b0);
    expect_v("restall_busy", 32'd1); chk(32'(a_busy));
    run_cyc(32'h40, 1'b1, 1'b0);
    expect_v("restall_done", 32'd1);  chk(32'(a_done));
    expect_v("restall_cycle", 32'd20); chk(a_cycle);

    // No commits: stall never halts, MAX_CYCLES=20 instance times out
    start_run();
    repeat (19) run_cyc(32'h0, 1'b1, 1'b0);
    expect_v("nocommit19_busy", 32'd1);    chk(32'(b_busy));
    expect_v("nocommit19_timeout", 32'd0); chk(32'(b_timeout));
    run_cyc(32'h0, 1'b1, 1'b0);
    expect_v("nocommit_timeout", 32'd1); chk(32'(b_timeout));
    expect_v("nocommit_done", 32'd0);    chk(32'(b_done));
    expect_v("nocommit_cycle", 32'd20);  chk(b_cycle);
    expect_v("nocommit_instr", 32'd0);   chk(b_instr);
    expect_v("nocommit_busy", 32'd0);    chk(32'(b_busy));
    expect_v("nocommit_no_halt_a", 32'd1); chk(32'(a_busy));

    // Abort on RUN cycle 7
    start_run();
    for (int i = 0; i < 6; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    abort = 1'b1;
    run_cyc(32'h18, 1'b0, 1'b1);
    abort = 1'b0;
    expect_v("abort_done", 32'd0);     chk(32'(a_done));
    expect_v("abort_timeout", 32'd0);  chk(32'(a_timeout));
    expect_v("abort_cycle", 32'd7);    chk(a_cycle);
    expect_v("abort_instr", 32'd7);    chk(a_instr);
    expect_v("abort_halt_pc", 32'h18); chk(a_halt_pc);
    expect_v("abort_busy", 32'd0);     chk(32'(a_busy));

    // Restart clears stats; a second start inside RESET must not stretch it
    start = 1'b1;
    step();
    start = 1'b0;
    expect_v("restart_busy", 32'd1);  chk(32'(a_busy));
    expect_v("restart_cycle", 32'd0); chk(a_cycle);
    expect_v("restart_instr", 32'd0); chk(a_instr);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    expect_v("busy_start_ignored_core_rst", 32'd0); chk(32'(a_core_rst));
    run_cyc(32'h0, 1'b0, 1'b0);
    run_cyc(32'h4, 1'b0, 1'b0);
    start = 1'b1;
    run_cyc(32'h8, 1'b0, 1'b0);
    start = 1'b0;
    expect_v("run_start_ignored_busy", 32'd1);  chk(32'(a_busy));
    expect_v("run_start_ignored_cycle", 32'd3); chk(a_cycle);

    // Abort inside RESET
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_v("reset_abort_busy", 32'd0);     chk(32'(a_busy));
    expect_v("reset_abort_cycle", 32'd0);    chk(a_cycle);
    expect_v("reset_abort_done", 32'd0);     chk(32'(a_done));
    expect_v("reset_abort_core_rst", 32'd1); chk(32'(a_core_rst));

    // Asynchronous reset mid-RUN, between clock edges
    start_run();
    for (int i = 0; i < 5; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    expect_v("pre_arst_cycle", 32'd5); chk(a_cycle);
    #3;
    rst_n = 1'b0;
    #1;
    expect_v("arst_core_rst", 32'd1); chk(32'(a_core_rst));
    expect_v("arst_busy", 32'd0);     chk(32'(a_busy));
    expect_v("arst_cycle", 32'd0);    chk(a_cycle);
    expect_v("arst_instr", 32'd0);    chk(a_instr);
    expect_v("arst_halt_pc", 32'd0);  chk(a_halt_pc);
    #1;
    rst_n = 1'b1;

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    expect_v("start_over_abort_busy", 32'd1); chk(32'(a_busy));

    // Saturation with 4-bit counters, commit every cycle
    start_run();
    for (int i = 0; i < 39; i++) run_cyc(32'(4 * i), 1'b0, 1'b1);
    expect_v("sat39_busy", 32'd1);    chk(32'(c_busy));
    expect_v("sat39_timeout", 32'd0); chk(32'(c_timeout));
    expect_v("sat39_instr", 32'd15);  chk(32'(c_instr));
    expect_v("sat39_cycle", 32'd15);  chk(32'(c_cycle));
    run_cyc(32'(4 * 39), 1'b0, 1'b1);
    expect_v("sat_timeout", 32'd1); chk(32'(c_timeout));
    expect_v("sat_done", 32'd0);    chk(32'(c_done));
    expect_v("sat_instr", 32'd15);  chk(32'(c_instr));
    expect_v("sat_cycle", 32'd15);  chk(32'(c_cycle));
    expect_v("sat_busy", 32'd0);    chk(32'(c_busy));

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
